// File: rtl/spi_xfer_arb_if.sv
// Bundle between the SPI transfer arbiter, its requesters and the attached spi_core.
// The arbiter uses the master modport; requesters and the core model sit on slave.
interface spi_xfer_arb_if #(
    parameter int DWIDTH = 8,
    parameter int NREQ   = 2
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        last;
    logic [NREQ*DWIDTH-1:0] wdata;
    logic [NREQ-1:0]        ack;
    logic [NREQ-1:0]        rvalid;
    logic [DWIDTH-1:0]      rdata;
    logic [NREQ-1:0]        ssel_n;
    logic                   core_cs;
    logic                   core_wr;
    logic                   core_rd;
    logic [DWIDTH-1:0]      core_din;
    logic [DWIDTH-1:0]      core_dout;
    logic                   core_done;

    modport master (
        input  req, last, wdata, core_dout, core_done,
        output ack, rvalid, rdata, ssel_n, core_cs, core_wr, core_rd, core_din
    );

    modport slave (
        output req, last, wdata, core_dout, core_done,
        input  ack, rvalid, rdata, ssel_n, core_cs, core_wr, core_rd, core_din
    );
endinterface

// File: rtl/spi_xfer_arb.sv
// Round-robin arbiter sharing one spi_core among NREQ burst requesters, each with its
// own slave select framed by CS_GAP cycles of setup and hold.
module spi_xfer_arb #(
    parameter int DWIDTH = 8,
    parameter int NREQ   = 2,
    parameter int CS_GAP = 3
) (
    input logic            clk,
    input logic            rst,
    spi_xfer_arb_if.master bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, START, BUSY, DRAIN, HOLD} state_e;

    state_e            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [NREQ-1:0]   ssel_n_q, ssel_n_d;
    logic [NREQ-1:0]   rvalid_q, rvalid_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic [NREQ-1:0]   grant_oh;
    logic [GW-1:0]     pick;
    logic              found;
    int                idx;

    assign grant_oh = NREQ'(1) << grant_q;

    // First requester at or after rr_ptr, wrapping past NREQ-1 back to 0.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req[idx[GW-1:0]]) begin
                found = 1'b1;
                pick  = idx[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            ssel_n_q <= '1;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            ssel_n_q <= ssel_n_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        ssel_n_d = ssel_n_q;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        unique case (state_q)
            IDLE: if (found) begin
                grant_d  = pick;
                ssel_n_d = ~(NREQ'(1) << pick);
                cnt_d    = 4'(CS_GAP);
                state_d  = SETUP;
            end
            SETUP: begin
                // Counter parks at 0 if the core is still busy with someone else's tail.
                cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
                if (cnt_q <= 4'd1 && bus.core_done) state_d = START;
            end
            START: begin
                last_d  = bus.last[grant_q];
                state_d = BUSY;
            end
            BUSY: if (!bus.core_done) state_d = DRAIN;
            DRAIN: if (bus.core_done) begin
                rdata_d  = bus.core_dout;
                rvalid_d = grant_oh;
                // A dropped request ends the burst after the byte in flight.
                if (!last_q && bus.req[grant_q]) begin
                    state_d = START;
                end else begin
                    cnt_d   = 4'(CS_GAP);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
                if (cnt_q <= 4'd1) begin
                    ssel_n_d = '1;
                    rr_ptr_d = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ack      = '0;
        bus.core_cs  = 1'b0;
        bus.core_wr  = 1'b0;
        bus.core_din = '0;
        if (state_q == START) begin
            bus.ack      = grant_oh;
            bus.core_cs  = 1'b1;
            bus.core_wr  = 1'b1;
            bus.core_din = bus.wdata[int'(grant_q)*DWIDTH +: DWIDTH];
        end
    end

    assign bus.core_rd = 1'b0;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.ssel_n  = ssel_n_q;
endmodule

// File: tb/tb_spi_xfer_arb.sv
// Bench for spi_xfer_arb: loopback core model, per-requester byte scoreboard and an
// expected-grant queue checked on every ack.
module tb_spi_xfer_arb;
    localparam int DW  = 8;
    localparam int NR  = 2;
    localparam int GAP = 3;
    localparam int LAT = 4;

    logic clk;
    logic rst;

    spi_xfer_arb_if #(.DWIDTH(DW), .NREQ(NR)) bus ();

    spi_xfer_arb #(.DWIDTH(DW), .NREQ(NR), .CS_GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int t_fall = 0;
    int t_rv = 0;
    int falls = 0;
    int wr_cnt = 0;
    bit first = 0;
    logic [NR-1:0] prev_ssel = '1;

    int        gexp[$];
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int id, input logic [7:0] b);
        if (id == 0) exp_q0.push_back(b);
        else         exp_q1.push_back(b);
    endtask

    // Loopback spi_core: busy for LAT cycles after a write, then returns the byte sent.
    initial begin
        int cnt = 0;
        logic [7:0] sh = '0;
        bus.core_done = 1'b1;
        bus.core_dout = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                bus.core_done = 1'b1;
                bus.core_dout = '0;
                cnt = 0;
            end else if (bus.core_wr) begin
                bus.core_done = 1'b0;
                sh  = bus.core_din;
                cnt = LAT;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.core_done = 1'b1;
                    bus.core_dout = sh;
                end
            end
        end
    end

    // Output monitor: grants, received bytes, select framing.
    initial forever begin
        @(posedge clk); #1;
        cyc++;
        chk("core_rd", bus.core_rd, 0);
        chk("ssel_1hot", $countones(~bus.ssel_n) <= 1, 1);
        if (core_wr_seen()) wr_cnt++;
        if (rst) begin
            if ((prev_ssel & ~bus.ssel_n) != '0) begin
                falls++;
                t_fall = cyc;
                first  = 1'b1;
            end
            if ((~prev_ssel & bus.ssel_n) != '0) chk("hold_gap", cyc - t_rv, GAP);
            if (bus.ack != '0) begin
                if (gexp.size() == 0) chk("ack_spurious", bus.ack, 0);
                else                  chk("ack_id", bus.ack, 32'(1) << gexp.pop_front());
                chk("ack_wr", {bus.core_cs, bus.core_wr}, 2'b11);
                if (first) begin
                    chk("setup_gap", cyc - t_fall, GAP);
                    first = 1'b0;
                end
            end
            if (bus.rvalid != '0) begin
                t_rv = cyc;
                if (bus.rvalid == 2'b01 && exp_q0.size() > 0)
                    chk("rdata0", bus.rdata, exp_q0.pop_front());
                else if (bus.rvalid == 2'b10 && exp_q1.size() > 0)
                    chk("rdata1", bus.rdata, exp_q1.pop_front());
                else
                    chk("rv_spurious", bus.rvalid, 0);
            end
        end else begin
            first = 1'b0;
        end
        prev_ssel = bus.ssel_n;
    end

    function automatic bit core_wr_seen();
        return bus.core_wr === 1'b1;
    endfunction

    task automatic run_burst(input int id, input int n, input logic [7:0] b0, input bit drop);
        int sent = 0;
        int w = 0;
        logic [7:0] b;
        b = b0;
        bus.wdata[id*DW +: DW] = b;
        bus.last[id] = (n == 1);
        bus.req[id]  = 1'b1;
        push(id, b);
        while (sent < n && w < 2000) begin
            @(posedge clk); #1;
            w++;
            if (bus.ack[id]) begin
                sent++;
                @(posedge clk); #1;
                if (drop) break;
                if (sent < n) begin
                    b = b0 + 8'(sent);
                    bus.wdata[id*DW +: DW] = b;
                    bus.last[id] = (sent == n - 1);
                    push(id, b);
                end
            end
        end
        bus.req[id]  = 1'b0;
        bus.last[id] = 1'b0;
        chk("burst_done", w < 2000, 1);
    endtask

    task automatic wait_idle();
        int w = 0;
        while (bus.ssel_n != '1 && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        chk("idle_to", w < 500, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int f0;
        int wr0;
        int w;
        rst       = 1'b0;
        bus.req   = '0;
        bus.last  = '0;
        bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ssel", bus.ssel_n, 2'b11);
        chk("rst_ack", bus.ack, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_cs", bus.core_cs, 0);
        chk("rst_wr", bus.core_wr, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_din", bus.core_din, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // single byte loopback
        gexp.push_back(0);
        run_burst(0, 1, 8'hA5, 1'b0);
        wait_idle();

        // three-byte burst, select held across bytes
        f0 = falls;
        repeat (3) gexp.push_back(1);
        run_burst(1, 3, 8'h01, 1'b0);
        wait_idle();
        chk("ssel_cont", falls - f0, 1);

        // both requesting: strict alternation
        gexp.push_back(0); gexp.push_back(1); gexp.push_back(0); gexp.push_back(1);
        fork
            begin run_burst(0, 1, 8'h10, 1'b0); run_burst(0, 1, 8'h11, 1'b0); end
            begin run_burst(1, 1, 8'h20, 1'b0); run_burst(1, 1, 8'h21, 1'b0); end
        join
        wait_idle();

        // request withdrawn mid-burst: one byte then HOLD
        wr0 = wr_cnt;
        gexp.push_back(0);
        run_burst(0, 3, 8'h30, 1'b1);
        wait_idle();
        repeat (10) @(posedge clk);
        #1;
        chk("wr_once", wr_cnt - wr0, 1);

        // reset while the core is shifting
        gexp.push_back(1);
        bus.wdata[DW +: DW] = 8'h55;
        bus.last[1] = 1'b1;
        bus.req[1]  = 1'b1;
        w = 0;
        while (!bus.ack[1] && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        chk("rst_ack_seen", w < 200, 1);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("midrst_ssel", bus.ssel_n, 2'b11);
        chk("midrst_ack", bus.ack, 0);
        chk("midrst_wr", bus.core_wr, 0);
        bus.req  = '0;
        bus.last = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_ssel", bus.ssel_n, 2'b11);
        chk("post_rst_rv", bus.rvalid, 0);

        // first grant after reset goes to lowest index
        gexp.push_back(0); gexp.push_back(1);
        fork
            run_burst(0, 1, 8'h60, 1'b0);
            run_burst(1, 1, 8'h61, 1'b0);
        join
        wait_idle();

        chk("gexp_left", gexp.size(), 0);
        chk("exp0_left", exp_q0.size(), 0);
        chk("exp1_left", exp_q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
